// File: rtl/poly_tone_synth_pkg.sv
// Shared constants for the polyphonic tone synth: note period table and FSM states.
package synth_pkg;
    localparam int NUM_SEMITONES = 12;

    typedef enum logic [1:0] {S_IDLE, S_LOOK, S_COMMIT} state_e;

    // Octave-1 half-less periods in 100 MHz clock cycles, C..B.
    function automatic logic [31:0] c1_period(input logic [3:0] note);
        case (note)
            4'd0:    return 32'd3057805;
            4'd1:    return 32'd2886184;
            4'd2:    return 32'd2724194;
            4'd3:    return 32'd2571298;
            4'd4:    return 32'd2426982;
            4'd5:    return 32'd2290765;
            4'd6:    return 32'd2162195;
            4'd7:    return 32'd2040840;
            4'd8:    return 32'd1926296;
            4'd9:    return 32'd1818182;
            4'd10:   return 32'd1716135;
            4'd11:   return 32'd1619816;
            default: return 32'd0;
        endcase
    endfunction
endpackage

// File: rtl/poly_tone_synth_if.sv
// Note command channel: valid/ready handshake carrying on/off, semitone and octave.
interface poly_tone_synth_if #(
    parameter int OCT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_on;
    logic [3:0]       cmd_note;
    logic [OCT_W-1:0] cmd_octave;

    modport master (output cmd_valid, cmd_on, cmd_note, cmd_octave, input cmd_ready);
    modport slave  (input cmd_valid, cmd_on, cmd_note, cmd_octave, output cmd_ready);
endinterface

// File: rtl/poly_tone_synth_voice.sv
// One square-wave oscillator: phase counts 0..half-1, square toggles on each wrap.
module tone_voice #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en_i,
    input  logic                restart_i,
    input  logic [PERIOD_W-1:0] half_i,
    output logic                square_o
);
    logic [PERIOD_W-1:0] half_q, phase_q;
    logic                square_q;
    logic                wrap;

    // half of 0 or 1 degenerates to a toggle every cycle rather than stalling.
    assign wrap     = (half_q <= PERIOD_W'(1)) || (phase_q >= half_q - PERIOD_W'(1));
    assign square_o = square_q & en_i;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            half_q   <= '0;
            phase_q  <= '0;
            square_q <= 1'b0;
        end else if (restart_i) begin
            half_q   <= half_i;
            phase_q  <= '0;
            square_q <= 1'b0;
        end else if (!en_i) begin
            phase_q  <= '0;
            square_q <= 1'b0;
        end else if (wrap) begin
            phase_q  <= '0;
            square_q <= ~square_q;
        end else begin
            phase_q  <= phase_q + PERIOD_W'(1);
        end
    end
endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave synth: command FSM, voice allocator with age ranks,
// saturating volume and a PWM mixer.
module poly_tone_synth
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PERIOD_W   = 32,
    parameter int VOL_W      = 4,
    parameter int OCT_W      = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    poly_tone_synth_if.slave      cmd,
    input  logic                  vol_up,
    input  logic                  vol_down,
    output logic [VOL_W-1:0]      volume,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  cmd_err,
    output logic                  pwm_out
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int MIX_W = VOL_W + IDX_W;
    localparam logic [IDX_W-1:0] OLDEST = IDX_W'(NUM_VOICES - 1);

    state_e                           state_q;
    logic                             ready_q, err_q;
    logic                             on_q;
    logic [3:0]                       note_q;
    logic [OCT_W-1:0]                 oct_q;
    logic [PERIOD_W-1:0]              half_q, period;
    logic [IDX_W-1:0]                 tgt_q, tgt_d;
    logic                             do_q, do_d;
    logic [NUM_VOICES-1:0]            active_q;
    logic [NUM_VOICES-1:0][3:0]       vnote_q;
    logic [NUM_VOICES-1:0][OCT_W-1:0] voct_q;
    logic [NUM_VOICES-1:0][IDX_W-1:0] rank_q;
    logic                             hit, free_found;
    logic [IDX_W-1:0]                 hit_idx, free_idx, old_idx;
    logic [NUM_VOICES-1:0]            square, restart;
    logic                             commit_on;
    logic [VOL_W-1:0]                 volume_q, volume_d;
    logic [MIX_W-1:0]                 mix_q, mix_d, carrier_q;
    logic                             pwm_q;

    assign cmd.cmd_ready = ready_q;
    assign cmd_err       = err_q;
    assign voice_active  = active_q;
    assign volume        = volume_q;
    assign pwm_out       = pwm_q;
    assign period        = PERIOD_W'(c1_period(note_q) >> oct_q);
    assign commit_on     = (state_q == S_COMMIT) && do_q && on_q;

    // Voice search: same-note match, lowest free slot, and the rank-oldest voice.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        old_idx    = '0;
        tgt_d      = '0;
        do_d       = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!hit && active_q[v] && vnote_q[v] == note_q && voct_q[v] == oct_q) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(v);
            end
            if (!free_found && !active_q[v]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
            if (active_q[v] && rank_q[v] == OLDEST) old_idx = IDX_W'(v);
        end
        if (!on_q) begin
            tgt_d = hit_idx;
            do_d  = hit;
        end else begin
            do_d  = 1'b1;
            tgt_d = hit ? hit_idx : (free_found ? free_idx : old_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            on_q     <= 1'b0;
            note_q   <= '0;
            oct_q    <= '0;
            half_q   <= '0;
            tgt_q    <= '0;
            do_q     <= 1'b0;
            active_q <= '0;
            vnote_q  <= '0;
            voct_q   <= '0;
            rank_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: if (cmd.cmd_valid && ready_q) begin
                    on_q    <= cmd.cmd_on;
                    note_q  <= cmd.cmd_note;
                    oct_q   <= cmd.cmd_octave;
                    err_q   <= cmd.cmd_note >= 4'(NUM_SEMITONES);
                    ready_q <= 1'b0;
                    state_q <= S_LOOK;
                end
                S_LOOK: if (note_q >= 4'(NUM_SEMITONES)) begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end else begin
                    half_q  <= period >> 1;
                    tgt_q   <= tgt_d;
                    do_q    <= do_d;
                    state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                    if (do_q && on_q) begin
                        // A free voice ages everyone; a reused one ages only its juniors.
                        for (int v = 0; v < NUM_VOICES; v++)
                            if (IDX_W'(v) != tgt_q && active_q[v] &&
                                (!active_q[tgt_q] || rank_q[v] < rank_q[tgt_q]))
                                rank_q[v] <= rank_q[v] + IDX_W'(1);
                        active_q[tgt_q] <= 1'b1;
                        rank_q[tgt_q]   <= '0;
                        vnote_q[tgt_q]  <= note_q;
                        voct_q[tgt_q]   <= oct_q;
                    end else if (do_q) begin
                        for (int v = 0; v < NUM_VOICES; v++)
                            if (active_q[v] && rank_q[v] > rank_q[tgt_q])
                                rank_q[v] <= rank_q[v] - IDX_W'(1);
                        active_q[tgt_q] <= 1'b0;
                        rank_q[tgt_q]   <= '0;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign restart[v] = commit_on && (tgt_q == IDX_W'(v));
        tone_voice #(.PERIOD_W(PERIOD_W)) u_voice (
            .clk       (clk),
            .resetn    (resetn),
            .en_i      (active_q[v]),
            .restart_i (restart[v]),
            .half_i    (half_q),
            .square_o  (square[v])
        );
    end

    always_comb begin
        volume_d = volume_q;
        if (vol_up && !vol_down && volume_q != '1)
            volume_d = volume_q + VOL_W'(1);
        else if (vol_down && !vol_up && volume_q != '0)
            volume_d = volume_q - VOL_W'(1);
    end

    always_comb begin
        mix_d = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (square[v]) mix_d = mix_d + MIX_W'(volume_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            volume_q  <= '0;
            mix_q     <= '0;
            carrier_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            volume_q  <= volume_d;
            mix_q     <= mix_d;
            carrier_q <= carrier_q + MIX_W'(1);
            pwm_q     <= carrier_q < mix_q;
        end
    end
endmodule

// File: tb/tb_poly_tone_synth.sv
// Bench for poly_tone_synth: vector tables, hand sequences and a randomized run
// against an age-list allocation model.
module tb_poly_tone_synth;
    localparam int NV = 4;
    localparam int OW = 3;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          vol_up = 1'b0, vol_down = 1'b0;
    logic [VW-1:0] volume;
    logic [NV-1:0] voice_active;
    logic          cmd_err, pwm_out;

    poly_tone_synth_if #(.OCT_W(OW)) bus ();

    poly_tone_synth #(.NUM_VOICES(NV), .PERIOD_W(32), .VOL_W(VW), .OCT_W(OW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd          (bus),
        .vol_up       (vol_up),
        .vol_down     (vol_down),
        .volume       (volume),
        .voice_active (voice_active),
        .cmd_err      (cmd_err),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    int unsigned C1 [12] = '{3057805, 2886184, 2724194, 2571298, 2426982, 2290765,
                             2162195, 2040840, 1926296, 1818182, 1716135, 1619816};

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // Reference model: voices plus an age list, newest first; rank = list position.
    bit m_act [NV];
    int m_note [NV];
    int m_oct [NV];
    int m_age [$];

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0; m_note[v] = 0; m_oct[v] = 0;
        end
        m_age.delete();
    endfunction

    function automatic void age_remove(int v);
        for (int i = 0; i < m_age.size(); i++)
            if (m_age[i] == v) begin
                m_age.delete(i);
                break;
            end
    endfunction

    function automatic int model_cmd(bit on, int note, int oct);
        int hit, t;
        hit = -1; t = -1;
        if (note > 11) return -1;
        for (int v = 0; v < NV; v++)
            if (hit < 0 && m_act[v] && m_note[v] == note && m_oct[v] == oct) hit = v;
        if (!on) begin
            if (hit >= 0) begin
                m_act[hit] = 0;
                age_remove(hit);
            end
            return hit;
        end
        if (hit >= 0) t = hit;
        else begin
            for (int v = 0; v < NV; v++) if (t < 0 && !m_act[v]) t = v;
            if (t < 0) t = m_age[m_age.size()-1];
        end
        age_remove(t);
        m_age.push_front(t);
        m_act[t] = 1; m_note[t] = note; m_oct[t] = oct;
        return t;
    endfunction

    function automatic logic [NV-1:0] model_act();
        logic [NV-1:0] a;
        for (int v = 0; v < NV; v++) a[v] = m_act[v];
        return a;
    endfunction

    function automatic logic [7:0] model_ranks();
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < m_age.size(); i++) r[m_age[i]*2 +: 2] = 2'(i);
        return r;
    endfunction

    function automatic logic [7:0] mask_rank(logic [7:0] r, logic [NV-1:0] act);
        logic [7:0] m;
        m = '0;
        for (int v = 0; v < NV; v++) if (act[v]) m[v*2 +: 2] = r[v*2 +: 2];
        return m;
    endfunction

    function automatic logic [31:0] exp_half(int note, int oct);
        return (C1[note] >> oct) >> 1;
    endfunction

    function automatic logic [31:0] get_half(int v);
        case (v)
            0: return dut.g_voice[0].u_voice.half_q;
            1: return dut.g_voice[1].u_voice.half_q;
            2: return dut.g_voice[2].u_voice.half_q;
            3: return dut.g_voice[3].u_voice.half_q;
            default: return 32'd0;
        endcase
    endfunction

    // Called at a negedge; returns after cmd_ready is back (or a bound expires).
    task automatic send_cmd(input bit on, input int note, input int oct,
                            output int errs, output int lat);
        int w;
        w = 0; errs = 0; lat = 0;
        while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
        if (w == 20) check("ready_wait", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1; bus.cmd_on = on;
        bus.cmd_note = 4'(note); bus.cmd_octave = OW'(oct);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 1;
        if (cmd_err) errs++;
        while (!bus.cmd_ready && lat < 20) begin
            @(negedge clk);
            lat++;
            if (cmd_err) errs++;
        end
    endtask

    typedef struct {
        logic up; logic dn; int reps; int exp_vol;
    } vol_vec_t;

    typedef struct {
        bit on; int note; int oct; logic [NV-1:0] exp_act; logic [7:0] exp_rank;
        int exp_tgt; int exp_err; int exp_lat;
    } cmd_vec_t;

    vol_vec_t vvec [7];
    cmd_vec_t cvec [10];

    initial begin
        int errs, lat, tgt, note, oct, cnt, hi, r;
        bit on;

        vvec[0] = '{1'b0, 1'b1,  2,  0};
        vvec[1] = '{1'b1, 1'b0, 20, 15};
        vvec[2] = '{1'b1, 1'b1,  1, 15};
        vvec[3] = '{1'b0, 1'b1,  3, 12};
        vvec[4] = '{1'b1, 1'b1,  1, 12};
        vvec[5] = '{1'b1, 1'b0,  1, 13};
        vvec[6] = '{1'b1, 1'b0,  5, 15};

        // exp_rank packs v3..v0, two bits each
        cvec[0] = '{1, 0,  4, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd0},  0, 0, 3};
        cvec[1] = '{1, 4,  4, 4'b0011, {2'd0, 2'd0, 2'd0, 2'd1},  1, 0, 3};
        cvec[2] = '{1, 7,  4, 4'b0111, {2'd0, 2'd0, 2'd1, 2'd2},  2, 0, 3};
        cvec[3] = '{1, 11, 4, 4'b1111, {2'd0, 2'd1, 2'd2, 2'd3},  3, 0, 3};
        cvec[4] = '{1, 2,  4, 4'b1111, {2'd1, 2'd2, 2'd3, 2'd0},  0, 0, 3};
        cvec[5] = '{1, 4,  4, 4'b1111, {2'd2, 2'd3, 2'd0, 2'd1},  1, 0, 3};
        cvec[6] = '{0, 4,  4, 4'b1101, {2'd1, 2'd2, 2'd0, 2'd0}, -1, 0, 3};
        cvec[7] = '{0, 5,  4, 4'b1101, {2'd1, 2'd2, 2'd0, 2'd0}, -1, 0, 3};
        cvec[8] = '{1, 13, 4, 4'b1101, {2'd1, 2'd2, 2'd0, 2'd0}, -1, 1, 2};
        cvec[9] = '{1, 5,  4, 4'b1111, {2'd2, 2'd3, 2'd0, 2'd1},  1, 0, 3};

        bus.cmd_valid = 1'b0; bus.cmd_on = 1'b0; bus.cmd_note = '0; bus.cmd_octave = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.cmd_ready), 64'(1));
        check("rst_active", 64'(voice_active), 64'(0));
        check("rst_volume", 64'(volume), 64'(0));
        check("rst_pwm", 64'(pwm_out), 64'(0));
        check("rst_err", 64'(cmd_err), 64'(0));
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            vol_up = vvec[i].up; vol_down = vvec[i].dn;
            repeat (vvec[i].reps) @(negedge clk);
            vol_up = 1'b0; vol_down = 1'b0;
            check($sformatf("vol_vec%0d", i), 64'(volume), 64'(vvec[i].exp_vol));
        end

        // A/4 at full volume: half-period and PWM duty while the square is high.
        send_cmd(1, 9, 4, errs, lat);
        void'(model_cmd(1, 9, 4));
        check("a4_active", 64'(voice_active), 64'(4'b0001));
        check("a4_half", 64'(get_half(0)), 64'(56818));
        check("a4_half_model", 64'(get_half(0)), 64'(exp_half(9, 4)));
        cnt = 0;
        while (!dut.g_voice[0].u_voice.square_o && cnt < 60000) begin
            @(negedge clk);
            cnt++;
        end
        check("a4_toggle_cycles", 64'(cnt), 64'(56818));
        repeat (4) @(negedge clk);
        hi = 0;
        repeat (64) begin @(negedge clk); if (pwm_out) hi++; end
        check("a4_pwm_duty", 64'(hi), 64'(15));

        vol_down = 1'b1;
        repeat (16) @(negedge clk);
        vol_down = 1'b0;
        check("vol_down16", 64'(volume), 64'(0));
        repeat (3) @(negedge clk);
        hi = 0;
        repeat (64) begin @(negedge clk); if (pwm_out) hi++; end
        check("mute_pwm", 64'(hi), 64'(0));
        check("mute_active", 64'(voice_active), 64'(4'b0001));
        vol_up = 1'b1;
        repeat (15) @(negedge clk);
        vol_up = 1'b0;
        send_cmd(0, 9, 4, errs, lat);
        void'(model_cmd(0, 9, 4));
        check("a4_off", 64'(voice_active), 64'(0));

        for (int i = 0; i < 10; i++) begin
            send_cmd(cvec[i].on, cvec[i].note, cvec[i].oct, errs, lat);
            void'(model_cmd(cvec[i].on, cvec[i].note, cvec[i].oct));
            check($sformatf("vec%0d_active", i), 64'(voice_active), 64'(cvec[i].exp_act));
            check($sformatf("vec%0d_rank", i), 64'(mask_rank(dut.rank_q, cvec[i].exp_act)),
                  64'(mask_rank(cvec[i].exp_rank, cvec[i].exp_act)));
            check($sformatf("vec%0d_err", i), 64'(errs), 64'(cvec[i].exp_err));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(cvec[i].exp_lat));
            if (cvec[i].exp_tgt >= 0)
                check($sformatf("vec%0d_half", i), 64'(get_half(cvec[i].exp_tgt)),
                      64'(exp_half(cvec[i].note, cvec[i].oct)));
            if (i == 5)
                check("retrig_phase", 64'(dut.g_voice[1].u_voice.phase_q), 64'(0));
        end

        for (int i = 0; i < 250; i++) begin
            on = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 19);
            note = (r < 18) ? (r % 6) : (12 + $urandom_range(0, 3));
            oct = $urandom_range(3, 4);
            send_cmd(on, note, oct, errs, lat);
            tgt = model_cmd(on, note, oct);
            check($sformatf("rnd%0d_active", i), 64'(voice_active), 64'(model_act()));
            check($sformatf("rnd%0d_rank", i), 64'(mask_rank(dut.rank_q, model_act())),
                  64'(model_ranks()));
            check($sformatf("rnd%0d_err", i), 64'(errs), 64'(note > 11 ? 1 : 0));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(note > 11 ? 2 : 3));
            if (on && tgt >= 0)
                check($sformatf("rnd%0d_half", i), 64'(get_half(tgt)), 64'(exp_half(note, oct)));
        end

        // Reset while a command sits in COMMIT.
        send_cmd(1, 0, 5, errs, lat);
        check("pre_rst_active", 64'(voice_active != '0), 64'(1));
        bus.cmd_valid = 1'b1; bus.cmd_on = 1'b1; bus.cmd_note = 4'd7; bus.cmd_octave = OW'(5);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("in_commit_ready", 64'(bus.cmd_ready), 64'(0));
        resetn = 1'b0;
        @(negedge clk);
        model_reset();
        check("commit_rst_active", 64'(voice_active), 64'(0));
        check("commit_rst_ready", 64'(bus.cmd_ready), 64'(1));
        check("commit_rst_volume", 64'(volume), 64'(0));
        check("commit_rst_pwm", 64'(pwm_out), 64'(0));
        resetn = 1'b1;
        @(negedge clk);
        send_cmd(1, 0, 4, errs, lat);
        void'(model_cmd(1, 0, 4));
        check("post_rst_active", 64'(voice_active), 64'(model_act()));
        check("post_rst_lat", 64'(lat), 64'(3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
